as2650_bus_bridge: RTL and testbench
====================================

// Module: as2650_bus_bridge
// PURPOSE
//  Parametrised external-bus bridge for the AS2650 core, successor to the fixed 13-bit zero-wait bus.
//  Decodes CPU bus cycles (OPREQ/RW/M_IO/D_C) onto NCH memory channels plus one I/O channel.
//  Each channel uses a req/ack handshake, with optional wait states and a timeout.
//  Returns OPACK to stall the CPU. Sits between the core and the wrapper's memory/peripheral ports.
// PARAMETERS
//  AW        15   CPU address width (13 reproduces the legacy map)
//  NCH       4    memory channels, power of 2, >=2; chosen by addr[AW-1 -: log2(NCH)]
//  WAIT_CYC  0    minimum extra cycles between ch_req and accepting ch_ack (0..15)
//  TIMEOUT   255  cycles in REQ without ack before forced completion (>=WAIT_CYC+1, <=255)
// PORTS
//  wb_clk_i    in   1          clock
//  wb_rst_i    in   1          asynchronous reset, active-high
//  cpu_addr    in   AW         CPU address
//  cpu_dout    in   8          CPU write data
//  cpu_rw      in   1          1=write, 0=read
//  cpu_opreq   in   1          operation request
//  cpu_m_io    in   1          1=memory, 0=I/O
//  cpu_d_c     in   1          I/O data(1)/control(0) select
//  cpu_din     out  8          read data to CPU
//  cpu_opack   out  1          1-cycle completion strobe
//  ch_req      out  NCH+1      one-hot request; bit NCH = I/O channel
//  ch_we       out  1          write enable, valid with ch_req
//  ch_addr     out  AW         address; I/O: {cpu_addr[AW-1:1],cpu_d_c}
//  ch_wdata    out  8          write data
//  ch_rdata    in   8*(NCH+1)  packed read data, channel i at [8i+7:8i]
//  ch_ack      in   NCH+1      per-channel acknowledge
//  bus_err     out  1          sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; cpu_din=8'h00.
//  Async assert; synchronous effect of deassert on the next clock edge.
//  FSM IDLE->REQ->DONE->HOLD->IDLE.
//  IDLE: on cpu_opreq=1, latch addr/rw/data/m_io/d_c, decode channel, go to REQ.
//    ch_req rises on the next edge; min latency opreq->opack = 2 cycles at WAIT_CYC=0.
//  REQ: ch_req, ch_we, ch_addr, ch_wdata held constant. Counter cnt starts at 0, +1 per cycle.
//    ch_ack of the selected channel is accepted when cnt>=WAIT_CYC; earlier acks are ignored.
//    On accepted ack: capture that channel's ch_rdata (reads only; writes leave cpu_din unchanged).
//      Drop ch_req and go to DONE.
//    If cnt==TIMEOUT: drop ch_req, cpu_din=8'hFF, set bus_err, go to DONE.
//    Ack and timeout in the same cycle: ack wins, no error.
//    Acks on non-selected channels are ignored.
//  DONE: cpu_opack=1 for exactly one cycle; go to HOLD.
//  HOLD: wait for cpu_opreq=0, then go to IDLE. A held opreq never starts a second access.
//  cpu_din holds its last value until the next completed read.
//  cpu_opreq dropping in REQ: the access still completes (no abort); opack still pulses.
//  Reset in any state: ch_req drops immediately; no partial write is signalled complete.
//  Counter is 8 bits and saturates; it never wraps.
// STRUCTURE
//  Package as2650_bus_pkg: state enum {IDLE,REQ,DONE,HOLD}, IO_CH index, RD_ERR=8'hFF.
//  One sub-module, as2650_chan_decode (combinational): addr/m_io -> one-hot channel select.
//  FSM, latches and counter live in the top module.
// TESTING
//  1 Mem read 0x0301, AW=13, NCH=4, ch0 acks at once, rdata=8'h05:
//    ch_req=5'b00001; opack 2 cycles after opreq; cpu_din=8'h05.
//  2 Write 8'h0D to 0x7016, AW=15, NCH=4:
//    ch_req=5'b01000, ch_we=1, ch_wdata=8'h0D, ch_addr=15'h7016; cpu_din unchanged.
//  3 I/O read, m_io=0, d_c=1, addr=0x0010:
//    ch_req bit4 set, ch_addr=0x0011; ack with 8'hA5 -> cpu_din=8'hA5.
//  4 WAIT_CYC=3, ch0 acks at cnt=1 and holds ack:
//    ack accepted at cnt=3; opack 5 cycles after opreq.
//  5 TIMEOUT=8, no ack:
//    ch_req held 9 cycles; cpu_din=8'hFF; bus_err=1 and stays 1 after next good access.
//  6 Reset mid-REQ, then opreq held high across DONE:
//    all outputs 0 after reset; exactly one ch_req pulse per opreq assertion.

Source files
------------

// File: rtl/as2650_bus_pkg.sv
// Shared types and constants for the AS2650 external-bus bridge.
package as2650_bus_pkg;

  // Bus-cycle sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } bus_state_t;

  // Read data returned to the CPU when a channel never answers
  localparam logic [7:0] RD_ERR = 8'hFF;

  // Wait/timeout counter is 8 bits wide and saturates at this value
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // The I/O channel sits just above the memory channels in ch_req/ch_ack
  function automatic int io_ch(input int nch);
    return nch;
  endfunction

endpackage

// File: rtl/as2650_chan_decode.sv
// Combinational channel select: memory cycles pick one of NCH channels from
// the top address bits, I/O cycles always go to the dedicated I/O channel.
module as2650_chan_decode
  import as2650_bus_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [$clog2(NCH)-1:0] chan_bits,
  input  logic                   m_io,
  output logic [NCH:0]           sel
);

  localparam int IO = io_ch(NCH);

  // One-hot select; exactly one bit set for every bus cycle type
  always_comb begin
    sel = '0;
    if (m_io) begin
      sel[NCH-1:0] = NCH'(1) << chan_bits;
    end else begin
      sel[IO] = 1'b1;
    end
  end

endmodule

// File: rtl/as2650_bus_bridge.sv
// AS2650 external-bus bridge: turns one CPU bus cycle into a req/ack
// handshake on a memory or I/O channel, with programmable wait states and a
// timeout, and returns a single-cycle completion strobe to stall the core.
module as2650_bus_bridge
  import as2650_bus_pkg::*;
#(
  parameter int AW       = 15,
  parameter int NCH      = 4,
  parameter int WAIT_CYC = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [7:0]             cpu_dout,
  input  logic                   cpu_rw,
  input  logic                   cpu_opreq,
  input  logic                   cpu_m_io,
  input  logic                   cpu_d_c,
  output logic [7:0]             cpu_din,
  output logic                   cpu_opack,
  output logic [NCH:0]           ch_req,
  output logic                   ch_we,
  output logic [AW-1:0]          ch_addr,
  output logic [7:0]             ch_wdata,
  input  logic [8*(NCH+1)-1:0]   ch_rdata,
  input  logic [NCH:0]           ch_ack,
  output logic                   bus_err
);

  localparam int         SW     = $clog2(NCH);
  // 9-bit so that the wait test (cnt+1 > WAIT_CYC) never becomes a constant
  localparam logic [8:0] WAIT_C = 9'(WAIT_CYC);
  localparam logic [7:0] TMO_C  = 8'(TIMEOUT);

  bus_state_t       state_q, state_d;

  // Request captured when the CPU cycle is accepted
  logic [NCH:0]     sel_p0;
  logic             we_p0;
  logic [AW-1:0]    addr_p0;
  logic [7:0]       wdata_p0;

  logic [7:0]       cnt_q;
  logic [7:0]       din_q;
  logic             err_q;

  logic [NCH:0]     dec_sel;
  logic             latch;
  logic             accept;
  logic             tmo;
  logic             ack_sel;
  logic             wait_ok;
  logic [7:0]       rdata_sel;
  logic [AW-1:0]    addr_fmt;

  as2650_chan_decode #(
    .NCH (NCH)
  ) u_dec (
    .chan_bits (cpu_addr[AW-1 -: SW]),
    .m_io      (cpu_m_io),
    .sel       (dec_sel)
  );

  // I/O cycles replace address bit 0 with the data/control select
  always_comb begin
    addr_fmt = cpu_addr;
    if (!cpu_m_io) begin
      addr_fmt = {cpu_addr[AW-1:1], cpu_d_c};
    end
  end

  // Read data of the channel that owns the current access
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i <= NCH; i++) begin
      if (sel_p0[i]) begin
        rdata_sel = rdata_sel | ch_rdata[8*i +: 8];
      end
    end
  end

  // Ack qualifiers: only the selected channel, only once the wait has elapsed
  always_comb begin
    ack_sel = |(ch_ack & sel_p0);
    wait_ok = ({1'b0, cnt_q} + 9'd1) > WAIT_C;
  end

  // Sequencer state register; reset pulls ch_req low immediately
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, capture/complete strobes and handshake outputs
  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    accept    = 1'b0;
    tmo       = 1'b0;
    ch_req    = '0;
    ch_we     = 1'b0;
    cpu_opack = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_opreq) begin
          latch   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        ch_req = sel_p0;
        ch_we  = we_p0;
        // A late ack that lands on the timeout cycle still counts as success
        if (ack_sel && wait_ok) begin
          accept  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TMO_C) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cpu_opack = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        // Wait for the CPU to release opreq so one request yields one access
        if (!cpu_opreq) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture, wait/timeout counter, read data and sticky error
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sel_p0   <= '0;
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      cnt_q    <= '0;
      din_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (latch) begin
        sel_p0   <= dec_sel;
        we_p0    <= cpu_rw;
        addr_p0  <= addr_fmt;
        wdata_p0 <= cpu_dout;
        cnt_q    <= '0;
      end else if (state_q == REQ && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (accept && !we_p0) begin
        din_q <= rdata_sel;
      end
      if (tmo) begin
        din_q <= RD_ERR;
        err_q <= 1'b1;
      end
    end
  end

  assign ch_addr  = addr_p0;
  assign ch_wdata = wdata_p0;
  assign cpu_din  = din_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_as2650_bus_bridge.sv
// Randomized bench for the AS2650 bus bridge with a transaction-level model.
module tb_as2650_bus_bridge;

  localparam int AW  = 15;
  localparam int NCH = 4;
  localparam int WC  = 2;
  localparam int TO  = 10;
  localparam int RDW = 8 * (NCH + 1);

  logic              wb_clk_i;
  logic              wb_rst_i;
  logic [AW-1:0]     cpu_addr;
  logic [7:0]        cpu_dout;
  logic              cpu_rw;
  logic              cpu_opreq;
  logic              cpu_m_io;
  logic              cpu_d_c;
  logic [7:0]        cpu_din;
  logic              cpu_opack;
  logic [NCH:0]      ch_req;
  logic              ch_we;
  logic [AW-1:0]     ch_addr;
  logic [7:0]        ch_wdata;
  logic [RDW-1:0]    ch_rdata;
  logic [NCH:0]      ch_ack;
  logic              bus_err;

  int n_total = 0;
  int n_bad   = 0;

  // Model state visible to the CPU across transactions
  logic [7:0] exp_din;
  logic       exp_err;

  as2650_bus_bridge #(
    .AW       (AW),
    .NCH      (NCH),
    .WAIT_CYC (WC),
    .TIMEOUT  (TO)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_rw    (cpu_rw),
    .cpu_opreq (cpu_opreq),
    .cpu_m_io  (cpu_m_io),
    .cpu_d_c   (cpu_d_c),
    .cpu_din   (cpu_din),
    .cpu_opack (cpu_opack),
    .ch_req    (ch_req),
    .ch_we     (ch_we),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_rdata  (ch_rdata),
    .ch_ack    (ch_ack),
    .bus_err   (bus_err)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(ch_req),    32'h0);
    chk({tag, "_we"},    32'(ch_we),     32'h0);
    chk({tag, "_opack"}, 32'(cpu_opack), 32'h0);
    chk({tag, "_addr"},  32'(ch_addr),   32'h0);
    chk({tag, "_wdata"}, 32'(ch_wdata),  32'h0);
    chk({tag, "_din"},   32'(cpu_din),   32'h0);
    chk({tag, "_err"},   32'(bus_err),   32'h0);
  endtask

  // One CPU bus cycle. ackpat[k] is the selected channel's ack while the
  // access has been pending k cycles; rfix>=0 forces the read byte.
  // Called at posedge+1; returns at posedge+1 with the bridge idle.
  task automatic run_txn(input logic [AW-1:0] a, input logic rw, input logic mio,
                         input logic dc, input logic [7:0] wd,
                         input logic [63:0] ackpat, input int drop_c, input int rfix);
    logic [NCH:0]  exp_sel;
    logic [AW-1:0] exp_addr;
    logic [7:0]    rpat [64];
    int            si;
    int            acc;
    bit            got;
    int            done_c;
    int            last_c;
    bit            in_req;
    logic [NCH:0]  ab;

    si       = mio ? int'(a[AW-1 -: 2]) : NCH;
    exp_sel  = (NCH+1)'(1) << si;
    exp_addr = mio ? a : {a[AW-1:1], dc};
    for (int k = 0; k < 64; k++) rpat[k] = (rfix >= 0) ? 8'(rfix) : 8'($urandom);

    acc = TO;
    got = 1'b0;
    for (int k = WC; k <= TO; k++) begin
      if (!got && ackpat[k]) begin
        acc = k;
        got = 1'b1;
      end
    end
    done_c = acc + 2;
    last_c = ((drop_c > done_c) ? drop_c : done_c) + 2;

    cpu_addr  = a;
    cpu_rw    = rw;
    cpu_m_io  = mio;
    cpu_d_c   = dc;
    cpu_dout  = wd;
    cpu_opreq = 1'b1;
    ch_ack    = (NCH+1)'($urandom);
    ch_rdata  = RDW'({$urandom(), $urandom()});

    for (int c = 1; c <= last_c; c++) begin
      @(posedge wb_clk_i);
      #1;
      in_req = (c <= acc + 1);
      chk("ch_req", 32'(ch_req), in_req ? 32'(exp_sel) : 32'h0);
      chk("ch_we", 32'(ch_we), 32'(in_req && rw));
      chk("opack", 32'(cpu_opack), 32'(c == done_c));
      if (c == 1) begin
        chk("ch_addr", 32'(ch_addr), 32'(exp_addr));
        chk("ch_wdata", 32'(ch_wdata), 32'(wd));
        chk("din_early", 32'(cpu_din), 32'(exp_din));
      end
      if (c == done_c) begin
        if (got) begin
          if (!rw) exp_din = rpat[acc];
        end else begin
          exp_din = 8'hFF;
          exp_err = 1'b1;
        end
        chk("cpu_din", 32'(cpu_din), 32'(exp_din));
        chk("bus_err", 32'(bus_err), 32'(exp_err));
      end
      cpu_opreq = (c < drop_c);
      ab = (NCH+1)'($urandom) & ~exp_sel;
      if (c - 1 < 64 && ackpat[c-1]) ab = ab | exp_sel;
      ch_ack   = ab;
      ch_rdata = RDW'({$urandom(), $urandom()});
      if (c - 1 < 64) ch_rdata[8*si +: 8] = rpat[c-1];
    end
  endtask

  function automatic logic [63:0] hold_from(input int d);
    logic [63:0] p;
    p = '0;
    for (int k = d; k < 64; k++) p[k] = 1'b1;
    return p;
  endfunction

  function automatic logic [63:0] rand_pat();
    logic [63:0] p;
    int          mode;
    p    = '0;
    mode = int'($urandom_range(0, 3));
    case (mode)
      0: p = '0;
      1: p = hold_from(int'($urandom_range(0, TO + 2)));
      2: for (int k = 0; k <= TO + 3; k++) p[k] = ($urandom_range(0, 3) == 0);
      default: p[$urandom_range(0, TO + 1)] = 1'b1;
    endcase
    return p;
  endfunction

  initial begin
    logic [63:0] p;
    logic [AW-1:0] ra;
    logic        rmio;

    wb_rst_i  = 1'b1;
    cpu_addr  = '0;
    cpu_dout  = '0;
    cpu_rw    = 1'b0;
    cpu_opreq = 1'b0;
    cpu_m_io  = 1'b1;
    cpu_d_c   = 1'b0;
    ch_rdata  = '0;
    ch_ack    = '0;
    exp_din   = 8'h00;
    exp_err   = 1'b0;

    repeat (2) @(posedge wb_clk_i);
    #1;
    chk_all_zero("rst");
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    chk("idle_req", 32'(ch_req), 32'h0);

    // Memory read on channel 0, immediate ack
    run_txn(15'h0301, 1'b0, 1'b1, 1'b0, 8'h00, hold_from(0), 1, 8'h05);
    // Write to top channel
    run_txn(15'h7016, 1'b1, 1'b1, 1'b0, 8'h0D, hold_from(0), 3, -1);
    // I/O data read
    run_txn(15'h0010, 1'b0, 1'b0, 1'b1, 8'h00, hold_from(0), 2, 8'hA5);
    // Early ack held: accepted once the wait elapses
    run_txn(15'h1234, 1'b0, 1'b1, 1'b0, 8'h00, hold_from(1), 7, -1);
    // Ack exactly on the timeout cycle wins
    p = '0;
    p[TO] = 1'b1;
    run_txn(15'h2345, 1'b0, 1'b1, 1'b0, 8'h00, p, 2, -1);
    // Single ack pulse before the wait elapses is ignored -> timeout
    p = '0;
    p[WC-1] = 1'b1;
    run_txn(15'h4567, 1'b0, 1'b1, 1'b0, 8'h00, p, 1, -1);
    // Good access afterwards; error stays set, opreq held well into HOLD
    run_txn(15'h6001, 1'b0, 1'b1, 1'b0, 8'h00, hold_from(3), 12, -1);

    // Reset while a write is pending
    cpu_addr  = 15'h5555;
    cpu_rw    = 1'b1;
    cpu_m_io  = 1'b1;
    cpu_dout  = 8'h3C;
    cpu_opreq = 1'b1;
    ch_ack    = '0;
    @(posedge wb_clk_i);
    #1;
    chk("pre_rst_req", 32'(ch_req), 32'h04);
    @(posedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    cpu_opreq = 1'b0;
    exp_din   = 8'h00;
    exp_err   = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i);
      #1;
      chk("post_rst_req", 32'(ch_req), 32'h0);
      chk("post_rst_ack", 32'(cpu_opack), 32'h0);
    end

    for (int t = 0; t < 60; t++) begin
      ra   = AW'($urandom);
      rmio = ($urandom_range(0, 3) != 0);
      p    = rand_pat();
      run_txn(ra, 1'($urandom), rmio, 1'($urandom), 8'($urandom), p,
              int'($urandom_range(1, TO + 6)), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
